// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic unit with a one-deep valid/ready output stage
// and an optional accumulator that can stand in for operand B.
module logic_unit_pipe #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [WIDTH-1:0] acc_q
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOTX = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0] sel,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOR:  r = ~(a | b);
      OP_NAND: r = ~(a & b);
      OP_XNOR: r = ~(a ^ b);
      OP_NOTX: r = ~a;
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             parity_q, parity_d;
  logic [WIDTH-1:0] acc_reg_q, acc_reg_d;

  logic             accept_s;
  logic             fire_s;
  logic [WIDTH-1:0] op_b_s;
  logic [WIDTH-1:0] res_s;

  // Handshake qualifiers; in_ready depends only on the output stage and out_ready.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept_s = in_valid && in_ready;
    fire_s   = out_valid_q && out_ready;
  end

  // Next-state for the output stage and the accumulator.
  always_comb begin
    if (acc_en) begin
      op_b_s = acc_reg_q;
    end else begin
      op_b_s = y;
    end
    res_s = logic_op(op, x, op_b_s);

    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    parity_d    = parity_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      result_d    = res_s;
      zero_d      = (res_s == {WIDTH{1'b0}});
      parity_d    = even_parity(res_s);
    end else if (fire_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // A clear wins over an accumulate landing on the same edge.
    if (acc_clr) begin
      acc_reg_d = ACC_INIT;
    end else if (accept_s && acc_en) begin
      acc_reg_d = res_s;
    end else begin
      acc_reg_d = acc_reg_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= {WIDTH{1'b0}};
      zero_q      <= 1'b1;
      parity_q    <= 1'b0;
      acc_reg_q   <= ACC_INIT;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      parity_q    <= parity_d;
      acc_reg_q   <= acc_reg_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign parity    = parity_q;
  assign acc_q     = acc_reg_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: a posedge model pushes expected results on
// accept and pops on fire; a negedge monitor compares every visible output.
module tb_logic_unit_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, y;
  logic [2:0]   op;
  logic         acc_en, acc_clr;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, parity;
  logic [W-1:0] acc_q;

  logic_unit_pipe #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .parity(parity), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] res; logic z; logic p; } exp_t;
  exp_t         sb[$];
  logic [W-1:0] model_acc;
  bit           started = 1'b0;
  int           n_total = 0;
  int           n_pass = 0;

  function automatic logic [W-1:0] ref_op(input int o, input logic [W-1:0] a, input logic [W-1:0] b);
    case (o)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      3: return ~(a | b);
      4: return ~(a & b);
      5: return ~(a ^ b);
      6: return ~a;
      default: return a;
    endcase
  endfunction

  function automatic logic ref_parity(input logic [W-1:0] v);
    int ones = 0;
    for (int i = 0; i < W; i++) ones += int'(v[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: transfers happen at the rising edge.
  always @(posedge clk) begin
    bit           hv, acc, fire;
    logic [W-1:0] b, r;
    exp_t         e;
    started <= 1'b1;
    if (!rst_n) begin
      sb.delete();
      model_acc = 8'h00;
    end else begin
      hv   = (sb.size() != 0);
      fire = hv && out_ready;
      acc  = in_valid && (!hv || out_ready);
      if (fire) void'(sb.pop_front());
      if (acc) begin
        b = acc_en ? model_acc : y;
        r = ref_op(int'(op), x, b);
        e.res = r; e.z = (r == 8'h00); e.p = ref_parity(r);
        sb.push_back(e);
      end
      if (acc_clr) model_acc = 8'h00;
      else if (acc && acc_en) model_acc = r;
    end
  end

  // Monitor: compare outputs mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() == 0 || out_ready));
      chk("acc_q", 32'(acc_q), 32'(model_acc));
      if (sb.size() != 0 && out_valid) begin
        chk("result", 32'(result), 32'(sb[0].res));
        chk("zero", 32'(zero), 32'(sb[0].z));
        chk("parity", 32'(parity), 32'(sb[0].p));
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] xi, input logic [W-1:0] yi,
                       input logic [2:0] oi, input logic en, input logic clr, input logic rdy);
    in_valid = v; x = xi; y = yi; op = oi; acc_en = en; acc_clr = clr; out_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, rdy);
  endtask

  initial begin
    int wait_cnt;
    rst_n = 1'b0;
    in_valid = 1'b1; x = 8'hA5; y = 8'h3C; op = 3'd0; acc_en = 1'b0; acc_clr = 1'b0;
    out_ready = 1'b1;
    // 1. reset with in_valid held high
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'h00);
    chk("rst_zero", 32'(zero), 32'd1);
    chk("rst_parity", 32'(parity), 32'd0);
    chk("rst_acc", 32'(acc_q), 32'h00);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    // 2. all ops back-to-back
    for (int i = 0; i < 8; i++) drive(1'b1, 8'hA5, 8'h3C, 3'(i), 1'b0, 1'b0, 1'b1);
    chk("op7_result", 32'(result), 32'hA5);
    idle(1'b1);
    // 3. backpressure: first op accepted, second offered during stall
    drive(1'b1, 8'hF0, 8'h0F, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'hF0, 8'h0F, 3'd2, 1'b0, 1'b0, 1'b0);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_result", 32'(result), 32'hFF);
    drive(1'b1, 8'hF0, 8'h0F, 3'd2, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 8'h33, 8'h0F, 3'd0, 1'b0, 1'b0, 1'b1);
    idle(1'b1); idle(1'b1);
    // 4. accumulate chain then clear
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 8'h01, 8'hFF, 3'd1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h02, 8'hFF, 3'd1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'h80, 8'hFF, 3'd1, 1'b1, 1'b0, 1'b1);
    chk("acc_chain", 32'(acc_q), 32'h83);
    chk("acc_chain_result", 32'(result), 32'h83);
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
    chk("acc_clr", 32'(acc_q), 32'h00);
    // 5. clear collides with accumulate
    drive(1'b1, 8'h0F, 8'h00, 3'd1, 1'b1, 1'b0, 1'b1);
    drive(1'b1, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b1, 1'b1);
    chk("collide_result", 32'(result), 32'hF0);
    chk("collide_acc", 32'(acc_q), 32'h00);
    idle(1'b1);
    // 6. reset while stalled
    drive(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    idle(1'b0);
    rst_n = 1'b1;
    chk("rst_stall_valid", 32'(out_valid), 32'd0);
    chk("rst_stall_acc", 32'(acc_q), 32'h00);
    idle(1'b1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      drive(logic'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 3'($urandom),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 15) == 0),
            logic'($urandom_range(0, 2) != 0));
    end
    rst_n = 1'b1;
    // bounded drain
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      idle(1'b1);
      wait_cnt++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
